// File: rtl/mapman_ring_mpu.sv
// Thread-program map manager: ring-allocated instruction-memory regions, CAM lookup, in-order reclaim.
// Optional MAPMAN_PERSIST_EN: lookups never release an entry (default: a lookup hit consumes it).
module mapman_ring_mpu #(
    parameter int NUM_ENTRY  = 16,
    parameter int WIDTH_ID   = 8,
    parameter int WIDTH_ADDR = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          I_Req_St,
    input  logic [WIDTH_ID-1:0]           I_ThreadID_St,
    input  logic [WIDTH_ADDR:0]           I_Length_St,
    output logic                          O_Ack_St,
    output logic                          O_Nack_St,
    output logic [WIDTH_ADDR-1:0]         O_Address_St,
    input  logic                          I_Req_Lookup,
    input  logic [WIDTH_ID-1:0]           I_ThreadID_Ld,
    output logic                          O_Ack_Lookup,
    output logic                          O_Hit,
    output logic [2*WIDTH_ADDR:0]         O_ThreadInfo,
    input  logic                          I_Req_Rel,
    input  logic [WIDTH_ID-1:0]           I_ThreadID_Rel,
    output logic [WIDTH_ADDR:0]           O_Used_Size,
    output logic [$clog2(NUM_ENTRY):0]    O_Num,
    output logic                          O_Full,
    output logic                          O_Empty,
    output logic                          O_Err
);

    localparam int PTR_W = $clog2(NUM_ENTRY);
    localparam int NUM_W = PTR_W + 1;
    localparam int LEN_W = WIDTH_ADDR + 1;
    localparam logic [LEN_W-1:0] MEM_WORDS = LEN_W'(1) << WIDTH_ADDR;
    localparam logic [NUM_W-1:0] FULL_CNT  = NUM_W'(NUM_ENTRY);

    typedef enum logic {S_IDLE, S_RESP} resp_state_e;

    logic [NUM_ENTRY-1:0]  valid_q, valid_d;
    logic [NUM_ENTRY-1:0]  done_q, done_d;
    logic [WIDTH_ID-1:0]   id_q   [NUM_ENTRY];
    logic [WIDTH_ID-1:0]   id_d   [NUM_ENTRY];
    logic [WIDTH_ADDR-1:0] addr_q [NUM_ENTRY];
    logic [WIDTH_ADDR-1:0] addr_d [NUM_ENTRY];
    logic [LEN_W-1:0]      len_q  [NUM_ENTRY];
    logic [LEN_W-1:0]      len_d  [NUM_ENTRY];

    logic [PTR_W-1:0]      wp_q, wp_d, rp_q, rp_d;
    logic [WIDTH_ADDR-1:0] head_q, head_d;
    logic [LEN_W-1:0]      used_q, used_d;
    logic [NUM_W-1:0]      num_q, num_d;
    logic                  err_q, err_d;

    resp_state_e           st_state_q, st_state_d, lk_state_q, lk_state_d;
    logic                  st_ok_q, st_ok_d;
    logic [WIDTH_ADDR-1:0] addr_st_q, addr_st_d;
    logic                  hit_q, hit_d;
    logic [2*WIDTH_ADDR:0] info_q, info_d;

    logic                  lk_hit, rel_hit, st_dup, st_accept, rc_fire;
    logic [PTR_W-1:0]      lk_idx, rel_idx;

    // Associative match over live entries; descending scan so the lowest index wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_idx  = '0;
        rel_hit = 1'b0;
        rel_idx = '0;
        st_dup  = 1'b0;
        for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
            if (valid_q[i] && !done_q[i]) begin
                if (id_q[i] == I_ThreadID_Ld) begin
                    lk_hit = 1'b1;
                    lk_idx = PTR_W'(i);
                end
                if (id_q[i] == I_ThreadID_Rel) begin
                    rel_hit = 1'b1;
                    rel_idx = PTR_W'(i);
                end
                if (id_q[i] == I_ThreadID_St) begin
                    st_dup = 1'b1;
                end
            end
        end
    end

    assign st_accept = I_Req_St && (I_Length_St != '0) && (I_Length_St <= (MEM_WORDS - used_q))
                       && (num_q != FULL_CNT) && !st_dup;
    assign rc_fire   = valid_q[rp_q] && done_q[rp_q];

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        head_d  = head_q;
        err_d   = err_q;

        if (rc_fire) begin
            valid_d[rp_q] = 1'b0;
            rp_d          = rp_q + 1'b1;
        end

        if (I_Req_Rel) begin
            if (rel_hit) begin
                done_d[rel_idx] = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

`ifdef MAPMAN_PERSIST_EN
`else
        if (I_Req_Lookup && lk_hit) begin
            done_d[lk_idx] = 1'b1;
        end
`endif

        // The slot at WP is never live when the table is not full, so no conflict with the marks above.
        if (st_accept) begin
            valid_d[wp_q] = 1'b1;
            done_d[wp_q]  = 1'b0;
            id_d[wp_q]    = I_ThreadID_St;
            addr_d[wp_q]  = head_q;
            len_d[wp_q]   = I_Length_St;
            wp_d          = wp_q + 1'b1;
            head_d        = head_q + WIDTH_ADDR'(I_Length_St);
        end

        used_d = used_q + (st_accept ? I_Length_St : '0) - (rc_fire ? len_q[rp_q] : '0);
        num_d  = num_q + NUM_W'(st_accept) - NUM_W'(rc_fire);

        st_state_d = I_Req_St ? S_RESP : S_IDLE;
        st_ok_d    = st_accept;
        addr_st_d  = st_accept ? head_q : addr_st_q;
        lk_state_d = I_Req_Lookup ? S_RESP : S_IDLE;
        hit_d      = I_Req_Lookup && lk_hit;
        info_d     = info_q;
        if (I_Req_Lookup) begin
            info_d = lk_hit ? {addr_q[lk_idx], len_q[lk_idx]} : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= '0;
            done_q     <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            head_q     <= '0;
            used_q     <= '0;
            num_q      <= '0;
            err_q      <= 1'b0;
            st_state_q <= S_IDLE;
            st_ok_q    <= 1'b0;
            addr_st_q  <= '0;
            lk_state_q <= S_IDLE;
            hit_q      <= 1'b0;
            info_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            head_q     <= head_d;
            used_q     <= used_d;
            num_q      <= num_d;
            err_q      <= err_d;
            st_state_q <= st_state_d;
            st_ok_q    <= st_ok_d;
            addr_st_q  <= addr_st_d;
            lk_state_q <= lk_state_d;
            hit_q      <= hit_d;
            info_q     <= info_d;
        end
    end

    // Payload fields are qualified by valid_q, so they need no reset.
    always_ff @(posedge clock) begin
        id_q   <= id_d;
        addr_q <= addr_d;
        len_q  <= len_d;
    end

    assign O_Ack_St     = (st_state_q == S_RESP) && st_ok_q;
    assign O_Nack_St    = (st_state_q == S_RESP) && !st_ok_q;
    assign O_Address_St = addr_st_q;
    assign O_Ack_Lookup = (lk_state_q == S_RESP);
    assign O_Hit        = hit_q;
    assign O_ThreadInfo = info_q;
    assign O_Used_Size  = used_q;
    assign O_Num        = num_q;
    assign O_Full       = (num_q == FULL_CNT);
    assign O_Empty      = (num_q == '0);
    assign O_Err        = err_q;

endmodule

// File: tb/tb_mapman_ring_mpu.sv
// Directed self-checking bench for mapman_ring_mpu (default parameters, MEM = 1024 words).
module tb_mapman_ring_mpu;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_Req_St;
    logic [7:0]  I_ThreadID_St;
    logic [10:0] I_Length_St;
    logic        O_Ack_St, O_Nack_St;
    logic [9:0]  O_Address_St;
    logic        I_Req_Lookup;
    logic [7:0]  I_ThreadID_Ld;
    logic        O_Ack_Lookup, O_Hit;
    logic [20:0] O_ThreadInfo;
    logic        I_Req_Rel;
    logic [7:0]  I_ThreadID_Rel;
    logic [10:0] O_Used_Size;
    logic [4:0]  O_Num;
    logic        O_Full, O_Empty, O_Err;

    int total = 0;
    int bad   = 0;

    mapman_ring_mpu #(.NUM_ENTRY(16), .WIDTH_ID(8), .WIDTH_ADDR(10)) dut (
        .clock(clock), .reset(reset),
        .I_Req_St(I_Req_St), .I_ThreadID_St(I_ThreadID_St), .I_Length_St(I_Length_St),
        .O_Ack_St(O_Ack_St), .O_Nack_St(O_Nack_St), .O_Address_St(O_Address_St),
        .I_Req_Lookup(I_Req_Lookup), .I_ThreadID_Ld(I_ThreadID_Ld),
        .O_Ack_Lookup(O_Ack_Lookup), .O_Hit(O_Hit), .O_ThreadInfo(O_ThreadInfo),
        .I_Req_Rel(I_Req_Rel), .I_ThreadID_Rel(I_ThreadID_Rel),
        .O_Used_Size(O_Used_Size), .O_Num(O_Num), .O_Full(O_Full), .O_Empty(O_Empty), .O_Err(O_Err)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        I_Req_St = 1'b0; I_ThreadID_St = '0; I_Length_St = '0;
        I_Req_Lookup = 1'b0; I_ThreadID_Ld = '0;
        I_Req_Rel = 1'b0; I_ThreadID_Rel = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive_store(input logic [7:0] id, input logic [10:0] len);
        I_Req_St = 1'b1; I_ThreadID_St = id; I_Length_St = len;
        tick();
        I_Req_St = 1'b0;
    endtask

    task automatic drive_lookup(input logic [7:0] id);
        I_Req_Lookup = 1'b1; I_ThreadID_Ld = id;
        tick();
        I_Req_Lookup = 1'b0;
    endtask

    task automatic drive_release(input logic [7:0] id);
        I_Req_Rel = 1'b1; I_ThreadID_Rel = id;
        tick();
        I_Req_Rel = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        I_Req_St = 1'b1; I_ThreadID_St = 8'd1; I_Length_St = 11'd5;
        tick();
        reset = 1'b0;
        I_Req_St = 1'b0;
        tick();
        total++; if (O_Ack_St !== 1'b0 || O_Nack_St !== 1'b0) begin bad++; $display("FAIL rst_st_pulse got=%b%b exp=00", O_Ack_St, O_Nack_St); end
        total++; if (O_Ack_Lookup !== 1'b0 || O_Hit !== 1'b0) begin bad++; $display("FAIL rst_lk_pulse got=%b%b exp=00", O_Ack_Lookup, O_Hit); end
        total++; if (O_ThreadInfo !== 21'd0 || O_Address_St !== 10'd0) begin bad++; $display("FAIL rst_data got=%0h/%0d exp=0/0", O_ThreadInfo, O_Address_St); end
        total++; if (O_Used_Size !== 11'd0 || O_Num !== 5'd0) begin bad++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", O_Used_Size, O_Num); end
        total++; if (O_Full !== 1'b0 || O_Empty !== 1'b1 || O_Err !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b%b exp=010", O_Full, O_Empty, O_Err); end
    endtask

    task automatic test_store_basic;
        do_reset();
        drive_store(8'd3, 11'd100);
        total++; if (O_Ack_St !== 1'b1 || O_Nack_St !== 1'b0) begin bad++; $display("FAIL basic_ack got=%b%b exp=10", O_Ack_St, O_Nack_St); end
        total++; if (O_Address_St !== 10'd0) begin bad++; $display("FAIL basic_addr got=%0d exp=0", O_Address_St); end
        total++; if (O_Used_Size !== 11'd100 || O_Num !== 5'd1) begin bad++; $display("FAIL basic_counts got=%0d/%0d exp=100/1", O_Used_Size, O_Num); end
        total++; if (O_Empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", O_Empty); end
        tick();
        total++; if (O_Ack_St !== 1'b0) begin bad++; $display("FAIL basic_pulse_len got=%b exp=0", O_Ack_St); end
    endtask

    task automatic test_wrap;
        do_reset();
        drive_store(8'd10, 11'd1000);
        total++; if (O_Ack_St !== 1'b1 || O_Address_St !== 10'd0) begin bad++; $display("FAIL wrap_first got=%b/%0d exp=1/0", O_Ack_St, O_Address_St); end
        drive_store(8'd11, 11'd30);
        total++; if (O_Nack_St !== 1'b1 || O_Used_Size !== 11'd1000) begin bad++; $display("FAIL wrap_nofit got=%b/%0d exp=1/1000", O_Nack_St, O_Used_Size); end
        drive_release(8'd10);
        total++; if (O_Used_Size !== 11'd1000) begin bad++; $display("FAIL wrap_rel1 got=%0d exp=1000", O_Used_Size); end
        tick();
        total++; if (O_Used_Size !== 11'd0 || O_Num !== 5'd0) begin bad++; $display("FAIL wrap_rel2 got=%0d/%0d exp=0/0", O_Used_Size, O_Num); end
        drive_store(8'd11, 11'd30);
        total++; if (O_Ack_St !== 1'b1 || O_Address_St !== 10'd1000) begin bad++; $display("FAIL wrap_cont got=%b/%0d exp=1/1000", O_Ack_St, O_Address_St); end
        drive_store(8'd12, 11'd10);
        total++; if (O_Ack_St !== 1'b1 || O_Address_St !== 10'd6) begin bad++; $display("FAIL wrap_mod got=%b/%0d exp=1/6", O_Ack_St, O_Address_St); end
        total++; if (O_Used_Size !== 11'd40 || O_Num !== 5'd2) begin bad++; $display("FAIL wrap_counts got=%0d/%0d exp=40/2", O_Used_Size, O_Num); end
    endtask

    task automatic test_ooo_release;
        do_reset();
        drive_store(8'd1, 11'd10);
        drive_store(8'd2, 11'd20);
        drive_store(8'd3, 11'd30);
        total++; if (O_Address_St !== 10'd30 || O_Used_Size !== 11'd60) begin bad++; $display("FAIL ooo_fill got=%0d/%0d exp=30/60", O_Address_St, O_Used_Size); end
        drive_release(8'd2);
        tick();
        total++; if (O_Used_Size !== 11'd60 || O_Num !== 5'd3) begin bad++; $display("FAIL ooo_wait got=%0d/%0d exp=60/3", O_Used_Size, O_Num); end
        drive_release(8'd1);
        tick();
        tick();
        total++; if (O_Used_Size !== 11'd30 || O_Num !== 5'd1) begin bad++; $display("FAIL ooo_reclaim got=%0d/%0d exp=30/1", O_Used_Size, O_Num); end
        total++; if (O_Err !== 1'b0) begin bad++; $display("FAIL ooo_err got=%b exp=0", O_Err); end
    endtask

    task automatic test_reject;
        do_reset();
        drive_store(8'd4, 11'd50);
        drive_store(8'd4, 11'd5);
        total++; if (O_Nack_St !== 1'b1 || O_Used_Size !== 11'd50 || O_Num !== 5'd1) begin bad++; $display("FAIL rej_dup got=%b/%0d/%0d exp=1/50/1", O_Nack_St, O_Used_Size, O_Num); end
        drive_store(8'd6, 11'd0);
        total++; if (O_Nack_St !== 1'b1 || O_Num !== 5'd1) begin bad++; $display("FAIL rej_zero got=%b/%0d exp=1/1", O_Nack_St, O_Num); end
        for (int i = 0; i < 15; i++) begin
            drive_store(8'(20 + i), 11'd1);
        end
        total++; if (O_Full !== 1'b1 || O_Num !== 5'd16) begin bad++; $display("FAIL rej_full got=%b/%0d exp=1/16", O_Full, O_Num); end
        drive_store(8'd40, 11'd1);
        total++; if (O_Nack_St !== 1'b1 || O_Used_Size !== 11'd65 || O_Num !== 5'd16) begin bad++; $display("FAIL rej_over got=%b/%0d/%0d exp=1/65/16", O_Nack_St, O_Used_Size, O_Num); end
    endtask

    task automatic test_lookup_twice;
        logic [20:0] info_exp;
        info_exp = {10'd12, 11'd40};
        do_reset();
        drive_store(8'd7, 11'd12);
        drive_store(8'd5, 11'd40);
        drive_lookup(8'd5);
        total++; if (O_Ack_Lookup !== 1'b1 || O_Hit !== 1'b1) begin bad++; $display("FAIL lk1_hit got=%b%b exp=11", O_Ack_Lookup, O_Hit); end
        total++; if (O_ThreadInfo !== info_exp) begin bad++; $display("FAIL lk1_info got=%0h exp=%0h", O_ThreadInfo, info_exp); end
        drive_lookup(8'd5);
`ifdef MAPMAN_PERSIST_EN
        total++; if (O_Ack_Lookup !== 1'b1 || O_Hit !== 1'b1 || O_ThreadInfo !== info_exp) begin bad++; $display("FAIL lk2_persist got=%b%b/%0h exp=11/%0h", O_Ack_Lookup, O_Hit, O_ThreadInfo, info_exp); end
`else
        total++; if (O_Ack_Lookup !== 1'b1 || O_Hit !== 1'b0 || O_ThreadInfo !== 21'd0) begin bad++; $display("FAIL lk2_consume got=%b%b/%0h exp=10/0", O_Ack_Lookup, O_Hit, O_ThreadInfo); end
`endif
        total++; if (O_Used_Size !== 11'd52 || O_Num !== 5'd2) begin bad++; $display("FAIL lk_counts got=%0d/%0d exp=52/2", O_Used_Size, O_Num); end
    endtask

    task automatic test_back_to_back;
        I_Req_St = 1'b1; I_ThreadID_St = 8'd8; I_Length_St = 11'd8;
        tick();
        total++; if (O_Ack_St !== 1'b1 || O_Address_St !== 10'd52) begin bad++; $display("FAIL b2b_first got=%b/%0d exp=1/52", O_Ack_St, O_Address_St); end
        I_ThreadID_St = 8'd9;
        tick();
        I_Req_St = 1'b0;
        total++; if (O_Ack_St !== 1'b1 || O_Address_St !== 10'd60) begin bad++; $display("FAIL b2b_second got=%b/%0d exp=1/60", O_Ack_St, O_Address_St); end
        tick();
        total++; if (O_Ack_St !== 1'b0 || O_Used_Size !== 11'd68) begin bad++; $display("FAIL b2b_end got=%b/%0d exp=0/68", O_Ack_St, O_Used_Size); end
        I_Req_Rel = 1'b1; I_ThreadID_Rel = 8'd8;
        I_Req_St = 1'b1; I_ThreadID_St = 8'd8; I_Length_St = 11'd4;
        tick();
        idle_inputs();
        total++; if (O_Nack_St !== 1'b1 || O_Used_Size !== 11'd68) begin bad++; $display("FAIL b2b_samecycle got=%b/%0d exp=1/68", O_Nack_St, O_Used_Size); end
        total++; if (O_Err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b exp=0", O_Err); end
    endtask

    task automatic test_miss_err;
        do_reset();
        drive_lookup(8'd9);
        total++; if (O_Ack_Lookup !== 1'b1 || O_Hit !== 1'b0 || O_ThreadInfo !== 21'd0) begin bad++; $display("FAIL miss_lookup got=%b%b/%0h exp=10/0", O_Ack_Lookup, O_Hit, O_ThreadInfo); end
        drive_release(8'd9);
        total++; if (O_Err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", O_Err); end
        tick();
        tick();
        tick();
        total++; if (O_Err !== 1'b1 || O_Empty !== 1'b1 || O_Used_Size !== 11'd0) begin bad++; $display("FAIL err_sticky got=%b/%b/%0d exp=1/1/0", O_Err, O_Empty, O_Used_Size); end
    endtask

    initial begin
        test_reset();
        test_store_basic();
        test_wrap();
        test_ooo_release();
        test_reject();
        test_lookup_twice();
        test_back_to_back();
        test_miss_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mapman_ring_mpu.md
# mapman_ring_mpu

Parametrised thread-program map manager for the MPU instruction memory. Allocates contiguous, wrap-around regions of instruction memory to thread programs on store, resolves thread-ID lookups from the dispatch unit through an associative table, and reclaims space in allocation order as entries are released. It sits between the instruction-memory store path and the dispatch unit. It replaces the fixed-size map manager with configurable table depth and ID/address widths, explicit miss/reject reporting, and FIFO space reclamation.

## Interface
- NUM_ENTRY, 16, table entries; power of two, ≥2
- WIDTH_ID, 8, thread-ID width
- WIDTH_ADDR, 10, instruction-memory address width; memory holds MEM = 2^WIDTH_ADDR words
- clock  in  1  single clock; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- I_Req_St  in  1  store request pulse
- I_ThreadID_St  in  WIDTH_ID  thread ID to store
- I_Length_St  in  WIDTH_ADDR+1  program length in words
- O_Ack_St  out  1  store accepted (1-cycle pulse)
- O_Nack_St  out  1  store rejected (1-cycle pulse)
- O_Address_St  out  WIDTH_ADDR  granted base address, valid with O_Ack_St
- I_Req_Lookup  in  1  lookup request pulse
- I_ThreadID_Ld  in  WIDTH_ID  thread ID to look up
- O_Ack_Lookup  out  1  lookup response pulse
- O_Hit  out  1  lookup hit, valid with O_Ack_Lookup
- O_ThreadInfo  out  lookup_t  {address, length}; zero on miss
- I_Req_Rel  in  1  explicit release pulse
- I_ThreadID_Rel  in  WIDTH_ID  thread ID to release
- O_Used_Size  out  WIDTH_ADDR+1  words currently allocated
- O_Num  out  $clog2(NUM_ENTRY)+1  live (allocated, not yet reclaimed) entries
- O_Full  out  1  O_Num == NUM_ENTRY
- O_Empty  out  1  O_Num == 0
- O_Err  out  1  sticky: release of unknown ID; cleared only by reset

## Operation
- Table: per entry Valid, Done, ThreadID, Address, Length. Entries are allocated in ring order at write pointer WP. Reclaim uses ring read pointer RP. Both pointers are $clog2(NUM_ENTRY) bits and wrap naturally.
- Memory ring: R_Head is the next free address, WIDTH_ADDR bits, modulo MEM. A program may wrap past MEM-1 to 0.
- Store accept requires all of: Length ≠ 0, Length ≤ MEM − Used, table not full, and no Valid & ~Done entry matching ID. Otherwise the store is Nacked and there is no state change.
- On accept: entry[WP] ← {Valid=1, Done=0, ID, Address=R_Head, Length}; R_Head += Length (mod MEM); WP++; Used += Length; O_Address_St = old R_Head.
- Lookup: CAM match over Valid & ~Done entries. If several entries match (impossible by construction), the lowest index wins.
- Release: a matching live entry gets Done ← 1. If there is no match, O_Err ← 1 and nothing else changes.
- Reclaim: each cycle, if entry[RP] is Valid & Done, clear Valid, RP++, Used −= Length, Num−−. At most one entry per cycle. An out-of-order release waits until all older entries are Done.
- Without PERSIST, a lookup hit also marks the entry Done; see Configuration.
- All checks use pre-edge state. Used and Num net all same-cycle +/− contributions.
- Same-cycle store of an ID being released or looked up: the duplicate check sees it as still live, so the store is Nacked.
- Response FSM per port: IDLE → RESP on request, RESP → IDLE next cycle. A request arriving while in RESP is accepted, giving back-to-back pulses. Throughput is one request per port per cycle.

## Timing
- Store, lookup and release are each registered with 1-cycle latency. The response is asserted the cycle after the request and lasts exactly 1 cycle.
- A reclaimed entry's space is visible to store checks 1 cycle after Done is set, at the earliest.
- Reset values: all pulses 0; O_ThreadInfo 0; O_Address_St 0; O_Used_Size 0; O_Num 0; O_Full 0; O_Empty 1; O_Err 0.
- Table valid bits, pointers and R_Head are also reset to 0.
- Reset mid-operation drops any pending response. No pulse is issued in the cycle after reset deasserts.

## Configuration
- MAPMAN_PERSIST_EN defined: a lookup never releases an entry. Entries are freed only through I_Req_Rel, so one program can be dispatched repeatedly.
- MAPMAN_PERSIST_EN undefined: a lookup hit marks the entry Done, giving consume-once semantics. I_Req_Rel remains functional.

## Test plan
- After reset, store ID 3 with length 100 → O_Ack_St next cycle, O_Address_St=0; then O_Used_Size=100, O_Num=1, O_Empty=0.
- With MEM=1024 and 1000 words used, store length 30 → O_Nack_St, Used stays 1000. Release the oldest entry of length 1000 → Used=0 two cycles later. Then store length 30 → Ack, and the address continues from the old R_Head with wrap mod 1024.
- Store IDs 1, 2, 3; release 2 → Used unchanged and O_Num=3. Release 1 → within 2 cycles entries 1 and 2 are both reclaimed and O_Num=1.
- Lookup of unknown ID 9 → O_Ack_Lookup=1, O_Hit=0, O_ThreadInfo=0. Release ID 9 → O_Err=1 and stays 1.
- Store a duplicate live ID, length 0, or into a full table (NUM_ENTRY stores) → Nack each time, no state change, O_Full=1.
- Lookup ID 5 twice. Without MAPMAN_PERSIST_EN → first lookup hits, second misses. With MAPMAN_PERSIST_EN → both hit with identical {address, length}.
